// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 UART receiver with a small receive FIFO.
//
// The serial input is synchronised, and a falling edge on it starts a frame.
// A down-counting baud timer samples the start bit at mid-bit, then the
// eight data bits (LSB first), then the stop bit. A good byte is pushed into
// a circular FIFO. A bad stop bit produces a frame_err pulse and the byte is
// dropped.
//
// Ports
//   wb_clk_i   in   1   system clock, rising edge
//   wb_rst_i   in   1   synchronous active-high reset
//   rx_i       in   1   asynchronous serial line, idles high
//   clkdiv     in  16   clock cycles per bit (values below 4 act as 4)
//   rx_data    out  8   byte at FIFO head (reads 0 while FIFO is empty)
//   rx_valid   out  1   FIFO not empty
//   rx_ready   in   1   pop request, honoured only while rx_valid is high
//   rx_count   out  5   bytes held in FIFO
//   rx_busy    out  1   receiver FSM is inside a frame
//   frame_err  out  1   one-cycle pulse: stop bit sampled low
//   overrun    out  1   one-cycle pulse: good byte dropped, FIFO full
module uart_rx_core #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rx_i,
    input  logic [15:0] clkdiv,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [4:0]  rx_count,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;

    logic          sync1, sync2, sync_prev;
    logic          fall;

    logic [15:0]   div_eff;
    logic [15:0]   div_q;
    logic [15:0]   baud_cnt;
    logic          sample;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;

    logic          start_frame;
    logic          push_req;
    logic          ferr_req;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          ovr_req;

    // Synchroniser and edge-detect flops. They reset to the idle (high)
    // level so that reset itself never looks like a start edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_i;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // A falling edge is required. A line that is held low never restarts
    // a frame.
    assign fall    = sync_prev & ~sync2;
    assign div_eff = (clkdiv < 16'd4) ? 16'd4 : clkdiv;
    assign sample  = (baud_cnt == 16'd0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        push_req    = 1'b0;
        ferr_req    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt   = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                // A high line at mid start bit is a glitch. Drop it
                // silently.
                if (sample) begin
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && (bit_cnt == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_nxt = IDLE;
                    push_req  = sync2;
                    ferr_req  = ~sync2;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Baud timer. The divider is latched at the start edge, so changes on
    // clkdiv only affect the next frame. The first reload is half a bit,
    // which centres every later sample in its bit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_q    <= 16'd4;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
        end else begin
            if (start_frame) begin
                div_q    <= div_eff;
                baud_cnt <= (div_eff >> 1) - 16'd1;
                bit_cnt  <= 3'd0;
            end else if (state != IDLE) begin
                baud_cnt <= sample ? (div_q - 16'd1) : (baud_cnt - 16'd1);
                if ((state == DATA) && sample) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if ((state == DATA) && sample) begin
            shift_q <= {sync2, shift_q[7:1]};
        end
    end

    // Receive FIFO. A pop in the same cycle frees the slot that a push
    // into a full FIFO needs, so only a push with no pop can overrun.
    assign full    = (count == 5'(FIFO_DEPTH));
    assign pop     = rx_valid & rx_ready;
    assign do_push = push_req & (~full | pop);
    assign ovr_req = push_req & full & ~pop;

    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 5'd0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count + 5'(do_push) - 5'(pop);
            frame_err <= ferr_req;
            overrun   <= ovr_req;
        end
    end

    assign rx_valid = (count != 5'd0);
    assign rx_count = count;
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
    assign rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed frames with a byte scoreboard.
// Bytes that should be stored are queued as they are sent. Every pop seen
// on the output is checked against the head of the queue.
module tb_uart_rx_core;

    localparam int DEPTH = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        rx_i     = 1'b1;
    logic [15:0] clkdiv   = 16'd16;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [4:0]  rx_count;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;

    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_ferr = 0;
    int          n_ovr  = 0;
    logic [7:0]  exp_q [$];

    logic        ferr_d = 1'b0;
    logic        ovr_d  = 1'b0;
    logic        hold_d = 1'b0;
    logic [7:0]  data_d = 8'h00;

    uart_rx_core #(.FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .rx_i      (rx_i),
        .clkdiv    (clkdiv),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor. It counts pulses, checks the pulse rules and data
    // hold, and checks popped bytes against the scoreboard.
    always @(negedge wb_clk_i) begin
        if (frame_err) n_ferr <= n_ferr + 1;
        if (overrun)   n_ovr  <= n_ovr + 1;
        if (frame_err | overrun) begin
            chk("pulse_exclusive", 32'(frame_err & overrun), 32'd0);
            chk("pulse_width", 32'((frame_err & ferr_d) | (overrun & ovr_d)), 32'd0);
        end
        ferr_d <= frame_err;
        ovr_d  <= overrun;
        if (hold_d && rx_valid) chk("data_stable", 32'(rx_data), 32'(data_d));
        hold_d <= rx_valid & ~rx_ready;
        data_d <= rx_data;
        if (rx_valid && rx_ready) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_bad++;
                $error("FAIL sb_underflow: observed pop of %0h expected no pop", rx_data);
            end
            if (exp_q.size() > 0) chk("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Send one frame; bit k is driven from edge t0+k*div. The stop bit is
    // sampled in the cycle after edge s = t0 + 2 + div/2 + 9*div (2 sync
    // flops, half-bit centring, 9 whole bits). The push lands on edge s+1.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_push,
                              input int div, input bit lat_chk, input bit pop_at_stop);
        int          t0;
        int          s;
        logic [9:0]  bits;
        bits = {stop, b, 1'b0};
        t0   = cyc;
        s    = t0 + 2 + div / 2 + 9 * div;
        if (expect_push) exp_q.push_back(b);
        for (int k = 0; k < 10; k++) begin
            rx_i = bits[k];
            for (int j = 0; j < div; j++) begin
                tick();
                if (lat_chk && cyc == s) begin
                    chk("lat_not_yet_valid", 32'(rx_valid), 32'd0);
                    chk("busy_in_stop", 32'(rx_busy), 32'd1);
                end
                if (lat_chk && cyc == s + 1) begin
                    chk("lat_valid", 32'(rx_valid), 32'd1);
                    chk("lat_idle", 32'(rx_busy), 32'd0);
                end
                if (pop_at_stop && cyc == s) rx_ready = 1'b1;
                if (pop_at_stop && cyc == s + 1) begin
                    rx_ready = 1'b0;
                    chk("full_push_pop_count", 32'(rx_count), 32'(DEPTH));
                end
            end
        end
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        for (int i = 0; i < 40 && rx_valid; i++) tick();
        idle(3);
        rx_ready = 1'b0;
        chk("drain_count", 32'(rx_count), 32'd0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int f0;
        int o0;
        logic [7:0] pbits [8];

        // Reset values
        idle(5);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_count", 32'(rx_count), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        wb_rst_i = 1'b0;
        idle(10);

        // Single byte with the latency check
        clkdiv = 16'd16;
        send_frame(8'h0A, 1'b1, 1'b1, 16, 1'b1, 1'b0);
        idle(20);
        chk("t1_data", 32'(rx_data), 32'h0A);
        chk("t1_count", 32'(rx_count), 32'd1);
        chk("t1_busy", 32'(rx_busy), 32'd0);
        drain();

        // Fill the FIFO, then overrun it
        send_frame(8'h0F, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        send_frame(8'h3D, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        send_frame(8'h01, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        send_frame(8'h02, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        chk("t2_count_full", 32'(rx_count), 32'd4);
        o0 = n_ovr;
        send_frame(8'hFF, 1'b1, 1'b0, 16, 1'b0, 1'b0); idle(8);
        chk("t2_overrun_once", 32'(n_ovr), 32'(o0 + 1));
        chk("t2_count_after_ovr", 32'(rx_count), 32'd4);
        chk("t2_head", 32'(rx_data), 32'h0F);
        drain();

        // Framing error, then the line is held low
        f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b0);
        idle(10);
        chk("t3_ferr_once", 32'(n_ferr), 32'(f0 + 1));
        chk("t3_count", 32'(rx_count), 32'd0);
        idle(100);
        chk("t3_low_no_start", 32'(rx_busy), 32'd0);
        rx_i = 1'b1;
        idle(20);
        // clkdiv changes mid-frame must not disturb the frame in flight
        fork
            begin
                idle(40);
                clkdiv = 16'd5;
                idle(40);
                clkdiv = 16'd16;
            end
        join_none
        send_frame(8'h3D, 1'b1, 1'b1, 16, 1'b0, 1'b0);
        idle(10);
        chk("t3_data", 32'(rx_data), 32'h3D);
        chk("t3_ferr_total", 32'(n_ferr), 32'(f0 + 1));
        drain();

        // 6-cycle glitch gives a false start
        f0 = n_ferr;
        o0 = n_ovr;
        rx_i = 1'b0;
        idle(6);
        rx_i = 1'b1;
        idle(4);
        chk("t4_busy_in_start", 32'(rx_busy), 32'd1);
        idle(30);
        chk("t4_busy_after", 32'(rx_busy), 32'd0);
        chk("t4_count", 32'(rx_count), 32'd0);
        chk("t4_no_ferr", 32'(n_ferr), 32'(f0));
        chk("t4_no_ovr", 32'(n_ovr), 32'(o0));

        // Stop bit lands on the same edge as a pop, with the FIFO full
        send_frame(8'h11, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        send_frame(8'h22, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        send_frame(8'h33, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        send_frame(8'h44, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        chk("t5_full", 32'(rx_count), 32'd4);
        o0 = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b1, 16, 1'b0, 1'b1);
        idle(8);
        chk("t5_count", 32'(rx_count), 32'd4);
        chk("t5_no_ovr", 32'(n_ovr), 32'(o0));
        drain();

        // Reset during bit 4 of 0x77, with one byte already queued
        send_frame(8'h5A, 1'b1, 1'b1, 16, 1'b0, 1'b0); idle(8);
        f0 = n_ferr;
        o0 = n_ovr;
        pbits[0] = 8'h77;
        rx_i = 1'b0;
        idle(16);
        for (int k = 0; k < 4; k++) begin
            rx_i = pbits[0][k];
            idle(16);
        end
        rx_i = pbits[0][4];
        idle(8);
        chk("t6_busy_mid", 32'(rx_busy), 32'd1);
        wb_rst_i = 1'b1;
        rx_i = 1'b1;
        exp_q.delete();
        idle(3);
        chk("t6_rst_valid", 32'(rx_valid), 32'd0);
        chk("t6_rst_count", 32'(rx_count), 32'd0);
        chk("t6_rst_busy", 32'(rx_busy), 32'd0);
        chk("t6_rst_data", 32'(rx_data), 32'd0);
        wb_rst_i = 1'b0;
        idle(40);
        chk("t6_no_push", 32'(rx_count), 32'd0);
        chk("t6_idle", 32'(rx_busy), 32'd0);
        chk("t6_no_ferr", 32'(n_ferr), 32'(f0));
        chk("t6_no_ovr", 32'(n_ovr), 32'(o0));
        send_frame(8'h0F, 1'b1, 1'b1, 16, 1'b0, 1'b0);
        idle(10);
        chk("t6_data", 32'(rx_data), 32'h0F);
        drain();

        // A divider below 4 acts as 4
        clkdiv = 16'd2;
        send_frame(8'hC3, 1'b1, 1'b1, 4, 1'b1, 1'b0);
        idle(10);
        chk("t7_data", 32'(rx_data), 32'hC3);
        drain();

        // 9600 baud at 40 MHz
        clkdiv = 16'd4167;
        send_frame(8'h0A, 1'b1, 1'b1, 4167, 1'b1, 1'b0);
        idle(10);
        chk("t8_data", 32'(rx_data), 32'h0A);
        drain();

        idle(2);
        chk("total_ferr", 32'(n_ferr), 32'd1);
        chk("total_ovr", 32'(n_ovr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, receive FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 wb_clk_i  input  1  single system clock; all state updates on the rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 rx_i  input  1  asynchronous serial line, 8N1, LSB first, idles high.
REQ-005 clkdiv  input  16  wb_clk_i cycles per bit; values below 4 are treated as 4.
REQ-006 rx_data  output  8  byte at the FIFO head; valid only while rx_valid is high.
REQ-007 rx_valid  output  1  FIFO not empty.
REQ-008 rx_ready  input  1  consumer pop; a pop occurs when rx_valid and rx_ready are both high on a clock edge.
REQ-009 rx_count  output  5  number of bytes currently in the FIFO.
REQ-010 rx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 overrun  output  1  one-cycle pulse when a valid byte is dropped because the FIFO is full.

Function
REQ-013 rx_i shall pass through a 2-flop synchronizer, initialised to 1, before any use.
- A third flop holds the previous synchronized value for edge detection.
REQ-014 FSM states shall be IDLE, START, DATA and STOP.
REQ-015 IDLE -> START on a synchronized 1->0 transition.
- The effective clkdiv is latched at this point and used for the whole frame.
- A line held continuously low shall never start a frame.
REQ-016 START: after floor(div/2) cycles, sample the line.
- Line low: enter DATA.
- Line high: false start; return to IDLE with no output pulse.
REQ-017 DATA: sample once every div cycles, 8 samples in total.
- Samples shift in LSB first.
- The 8th sample moves the FSM to STOP.
REQ-018 STOP: sample after div cycles.
- Line high: push the byte into the FIFO.
- Line low: pulse frame_err and discard the byte.
- Either case returns the FSM to IDLE in the same cycle.
REQ-019 Timing: the baud counter shall be a down-counter reloaded with div-1 on each sample.
- A sample occurs on the cycle the counter reaches 0.
REQ-020 Latency: rx_valid shall rise and rx_data shall show the byte on the clock edge after the stop-bit sample edge.
REQ-021 FIFO: circular buffer with separate read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH.
- rx_count = writes - reads, range 0..FIFO_DEPTH.
REQ-022 Push when full with no pop in the same cycle: drop the byte, pulse overrun, leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle while full: both are accepted and rx_count stays at FIFO_DEPTH.
REQ-024 Push and pop in the same cycle at any other count: both are accepted and rx_count is unchanged.
REQ-025 A pop while empty shall be ignored; rx_ready is don't-care when rx_valid is low.
REQ-026 rx_data shall remain stable while rx_valid is high and no pop occurs.
REQ-027 frame_err and overrun shall never be high together and never last longer than one cycle.
REQ-028 A change on clkdiv mid-frame shall not affect the current frame.

Reset
REQ-029 While wb_rst_i is high:
- FSM = IDLE.
- FIFO pointers and rx_count = 0.
- rx_valid = 0, rx_busy = 0, frame_err = 0, overrun = 0, rx_data = 8'h00.
- Synchronizer flops = 1.
REQ-030 A reset asserted mid-frame shall abandon the partial byte without pushing it or pulsing any error.
- The next frame shall be accepted only after a fresh falling edge that occurs after reset is released.

Verification
REQ-031 clkdiv=16; send 0x0A with a valid stop bit.
- Required: rx_valid rises 1 cycle after the stop sample; rx_data=0x0A; rx_count=1; rx_busy low afterwards.
REQ-032 clkdiv=16, rx_ready=0; send 0x0F, 0x3D, 0x01, 0x02, then 0xFF.
- Required: rx_count=4; overrun pulses once for 0xFF.
- Then pop 4 times: bytes come out in order 0x0F, 0x3D, 0x01, 0x02.
REQ-033 clkdiv=16; send 0x55 with the stop bit driven low.
- Required: frame_err pulses once; rx_count stays 0.
- Line held low afterwards: no new frame starts.
- Line high, then a new frame of 0x3D: received correctly.
REQ-034 clkdiv=16; 6-cycle low glitch on rx_i.
- Required: false start; return to IDLE; no push, no pulses.
REQ-035 clkdiv=16; with FIFO full and rx_ready=1, the stop bit of 0xA5 lands in the same cycle as a pop.
- Required: no overrun; rx_count stays 4; 0xA5 is last in pop order.
REQ-036 Assert wb_rst_i during bit 4 of a frame.
- Required: outputs at reset values; no push; the following 0x0F frame is received correctly.
- clkdiv=4167 (40 MHz clock, 9600 baud), send 0x0A: rx_data=0x0A.
